// File: rtl/fir_pkg.sv
// Shared types and default sizing for the multi-channel FIR delay line.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_t;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_TAPS     = 32;
  localparam int DEF_CHANNELS = 1;
  localparam int DEF_CNT_W    = 14;

  // Number of zero shifts needed to push the last real sample to the oldest tap.
  function automatic int flush_len(input int taps);
    return taps - 1;
  endfunction

endpackage

// File: rtl/fir_delay_line_mc_if.sv
// Control/data bundle between the sample RAM / MAC controller (master) and the delay line (slave).
interface fir_delay_line_mc_if #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 1,
  parameter int CNT_W    = 14,
  parameter int ADDR_W   = 5
);

  logic                       start;
  logic [CNT_W-1:0]           ile_probek;
  logic                       nowa_shift;
  logic [CHANNELS*DATA_W-1:0] probka_in;
  logic [ADDR_W-1:0]          adres;
  logic [CHANNELS*DATA_W-1:0] out;
  logic [CNT_W-1:0]           probka_idx;
  logic                       drain;
  logic                       koniec;

  modport master (
    output start, ile_probek, nowa_shift, probka_in, adres,
    input  out, probka_idx, drain, koniec
  );

  modport slave (
    input  start, ile_probek, nowa_shift, probka_in, adres,
    output out, probka_idx, drain, koniec
  );

endinterface

// File: rtl/fir_tap_line.sv
// One channel of the delay line: TAPS-deep shift register with a registered tap read.
module fir_tap_line
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] adres,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_line [TAPS];
  logic [DATA_W-1:0] w_src  [TAPS];
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] r_dout;

  // Each stage takes its predecessor; stage 0 takes the new sample.
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign w_src[gi] = din;
      end else begin : g_body
        assign w_src[gi] = r_line[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) r_line[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < TAPS; i++) r_line[i] <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < TAPS; i++) r_line[i] <= w_src[i];
    end
  end

  // Addresses past the last tap exist only when TAPS is not a power of two; they read as 0.
  always_comb begin
    w_rd = '0;
    if (int'(adres) < TAPS) w_rd = r_line[adres];
  end

  // Sampled from the pre-shift contents, so a read alongside a shift sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_dout <= '0;
    else     r_dout <= w_rd;
  end

  assign dout = r_dout;

endmodule

// File: rtl/fir_delay_line_mc.sv
// Multi-channel FIR delay line with run sequencing: load ile_probek samples, flush TAPS-1 zeros, flag koniec.
module fir_delay_line_mc
  import fir_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int ADDR_W   = $clog2(TAPS)
) (
  input logic               clk,
  input logic               rst,
  fir_delay_line_mc_if.slave bus
);

  localparam int DC_W = (TAPS > 2) ? $clog2(TAPS) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(flush_len(TAPS) - 1);

  fir_state_t       r_state;
  fir_state_t       w_state_next;
  logic [CNT_W-1:0] r_ile;
  logic [CNT_W-1:0] r_probka_idx;
  logic [CNT_W-1:0] w_idx_inc;
  logic [DC_W-1:0]  r_drain_cnt;
  logic             w_shift_en;
  logic             w_fill_shift;
  logic             w_drain_shift;
  logic             w_fill_shift_n;

  logic [CHANNELS*DATA_W-1:0] w_din;
  logic [CHANNELS*DATA_W-1:0] w_out;

  assign w_idx_inc = r_probka_idx + 1'b1;

  // start wins over a same-cycle shift in every state.
  assign w_fill_shift  = bus.nowa_shift && !bus.start && (r_state == ST_FILL);
  assign w_drain_shift = bus.nowa_shift && !bus.start && (r_state == ST_DRAIN);
  assign w_shift_en    = w_fill_shift || w_drain_shift;
  assign w_fill_shift_n = !w_fill_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.start) begin
      w_state_next = (bus.ile_probek == '0) ? ST_DONE : ST_FILL;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_next = ST_IDLE;
        ST_FILL:  if (w_fill_shift && (w_idx_inc == r_ile)) w_state_next = ST_DRAIN;
        ST_DRAIN: if (w_drain_shift && (r_drain_cnt == DRAIN_LAST)) w_state_next = ST_DONE;
        ST_DONE:  w_state_next = ST_DONE;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ile        <= '0;
      r_probka_idx <= '0;
      r_drain_cnt  <= '0;
    end else if (bus.start) begin
      r_ile        <= bus.ile_probek;
      r_probka_idx <= '0;
      r_drain_cnt  <= '0;
    end else if (w_fill_shift) begin
      r_probka_idx <= w_idx_inc;
    end else if (w_drain_shift) begin
      r_drain_cnt  <= r_drain_cnt + 1'b1;
    end
  end

  // Zeros are fed to every channel while draining.
  assign w_din = w_fill_shift_n ? '0 : bus.probka_in;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      fir_tap_line #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
      ) u_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (w_shift_en),
        .clear    (bus.start),
        .din      (w_din[gi*DATA_W +: DATA_W]),
        .adres    (bus.adres),
        .dout     (w_out[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign bus.out        = w_out;
  assign bus.probka_idx = r_probka_idx;
  assign bus.drain      = (r_state == ST_DRAIN);
  assign bus.koniec     = (r_state == ST_DONE);

endmodule

// File: tb/tb_fir_delay_line_mc.sv
// Directed checks of the delay line with TAPS=5, two channels, hand-computed expectations.
module tb_fir_delay_line_mc;

  localparam int DATA_W   = 16;
  localparam int TAPS     = 5;
  localparam int CHANNELS = 2;
  localparam int CNT_W    = 14;
  localparam int ADDR_W   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  fir_delay_line_mc_if #(
    .DATA_W(DATA_W), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) bus ();

  fir_delay_line_mc #(
    .DATA_W(DATA_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int c0, input int c1);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(c0);
    b = 16'(c1);
    return {b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  task automatic do_start(input int n);
    bus.start      = 1'b1;
    bus.ile_probek = CNT_W'(n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_shift(input int c0, input int c1);
    bus.nowa_shift = 1'b1;
    bus.probka_in  = pk(c0, c1);
    tick();
    bus.nowa_shift = 1'b0;
  endtask

  task automatic read_tap(input int a, output logic [31:0] v);
    bus.adres = ADDR_W'(a);
    tick();
    v = bus.out;
  endtask

  logic [31:0] v;

  initial begin
    bus.start = 1'b0; bus.ile_probek = '0; bus.nowa_shift = 1'b0;
    bus.probka_in = '0; bus.adres = '0;
    tick(); tick();
    chk("rst_out", bus.out, 32'h0);
    chk("rst_idx", 32'(bus.probka_idx), 32'h0);
    chk("rst_koniec", 32'(bus.koniec), 32'h0);
    chk("rst_drain", 32'(bus.drain), 32'h0);
    rst = 1'b0;
    tick();

    // T1: asynchronous reset in the middle of FILL
    do_start(10);
    do_shift(1, -1); do_shift(2, -2); do_shift(3, -3);
    chk("t1_idx_pre", 32'(bus.probka_idx), 32'd3);
    read_tap(0, v);
    chk("t1_tap0_pre", v, pk(3, -3));
    #2 rst = 1'b1;
    #1;
    chk("t1_async_out", bus.out, 32'h0);
    chk("t1_async_idx", 32'(bus.probka_idx), 32'h0);
    tick();
    rst = 1'b0;
    for (int a = 0; a < TAPS; a++) begin
      read_tap(a, v);
      chk($sformatf("t1_tap%0d", a), v, 32'h0);
    end
    do_shift(9, 9);
    read_tap(0, v);
    chk("t1_idle_noshift", v, 32'h0);
    chk("t1_koniec", 32'(bus.koniec), 32'h0);

    // T2: three samples then four zero-flush shifts
    do_start(3);
    bus.ile_probek = 14'd9;
    chk("t2_idx0", 32'(bus.probka_idx), 32'h0);
    do_shift(1, -1); do_shift(2, -2); do_shift(3, -3);
    chk("t2_idx3", 32'(bus.probka_idx), 32'd3);
    chk("t2_drain_on", 32'(bus.drain), 32'd1);
    read_tap(0, v); chk("t2_tap0", v, pk(3, -3));
    read_tap(1, v); chk("t2_tap1", v, pk(2, -2));
    read_tap(2, v); chk("t2_tap2", v, pk(1, -1));
    for (int z = 0; z < TAPS - 1; z++) begin
      chk($sformatf("t2_drain_z%0d", z), 32'(bus.drain), 32'd1);
      do_shift(7, 7);
    end
    chk("t2_koniec", 32'(bus.koniec), 32'd1);
    chk("t2_drain_off", 32'(bus.drain), 32'd0);
    do_shift(8, 8); do_shift(8, 8);
    read_tap(4, v); chk("t2_tap4_last", v, pk(3, -3));
    read_tap(0, v); chk("t2_tap0_zero", v, 32'h0);
    chk("t2_idx_hold", 32'(bus.probka_idx), 32'd3);

    // T3: empty run
    do_start(0);
    chk("t3_koniec", 32'(bus.koniec), 32'd1);
    do_shift(16'h55, 16'h55); do_shift(16'h55, 16'h55);
    read_tap(0, v); chk("t3_tap0", v, 32'h0);
    read_tap(4, v); chk("t3_tap4_clr", v, 32'h0);
    chk("t3_idx", 32'(bus.probka_idx), 32'h0);

    // T4: read/shift collision and out-of-range address
    do_start(20);
    do_shift(16'h11, 16'h22);
    bus.adres = '0;
    bus.nowa_shift = 1'b1;
    bus.probka_in  = pk(16'hAB, 16'hCD);
    tick();
    bus.nowa_shift = 1'b0;
    chk("t4_old", bus.out, pk(16'h11, 16'h22));
    tick();
    chk("t4_new", bus.out, pk(16'hAB, 16'hCD));
    read_tap(5, v); chk("t4_adr5", v, 32'h0);
    read_tap(7, v); chk("t4_adr7", v, 32'h0);

    // T5: start together with a shift at idx=7
    for (int k = 0; k < 5; k++) do_shift(100 + k, 100 + k);
    chk("t5_idx7", 32'(bus.probka_idx), 32'd7);
    bus.start = 1'b1; bus.nowa_shift = 1'b1; bus.probka_in = pk(77, 77);
    tick();
    bus.start = 1'b0; bus.nowa_shift = 1'b0;
    chk("t5_idx0", 32'(bus.probka_idx), 32'h0);
    chk("t5_koniec", 32'(bus.koniec), 32'h0);
    for (int a = 0; a < TAPS; a++) begin
      read_tap(a, v);
      chk($sformatf("t5_tap%0d", a), v, 32'h0);
    end

    // T6: 40 samples on two channels, +k and -k
    do_start(40);
    for (int k = 1; k <= 40; k++) do_shift(k, -k);
    chk("t6_idx40", 32'(bus.probka_idx), 32'd40);
    chk("t6_drain", 32'(bus.drain), 32'd1);
    read_tap(0, v); chk("t6_tap0", v, pk(40, -40));
    read_tap(4, v); chk("t6_tap4", v, pk(36, -36));
    for (int z = 0; z < TAPS - 2; z++) do_shift(1, 1);
    chk("t6_drain_last", 32'(bus.drain), 32'd1);
    do_shift(1, 1);
    chk("t6_koniec", 32'(bus.koniec), 32'd1);
    read_tap(4, v); chk("t6_tap4_end", v, pk(40, -40));
    read_tap(3, v); chk("t6_tap3_end", v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
